// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M multiply/divide unit with start/busy/done handshake
module muldiv_unit #(
  parameter  int XLEN  = 32,
  localparam int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      func3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t            state;
  logic [2:0]        f3_q;
  logic              a_neg;
  logic              b_neg;
  logic [XLEN-1:0]   mag_a;
  logic [XLEN-1:0]   mag_b;
  logic [2*XLEN-1:0] acc;
  logic [CNT_W-1:0]  cnt;

  logic              in_a_neg;
  logic              in_b_neg;
  logic [XLEN-1:0]   in_mag_a;
  logic [XLEN-1:0]   in_mag_b;
  logic              div_zero;
  logic              div_ovf;
  logic [XLEN-1:0]   special_res;
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  logic [XLEN:0]     div_shift;
  logic [XLEN:0]     div_diff;
  logic [2*XLEN-1:0] div_next;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quot;
  logic [XLEN-1:0]   remv;
  logic [XLEN-1:0]   fix_res;

  // Decode the incoming request: operand signs, magnitudes and the short-circuit cases
  always_comb begin
    in_a_neg = 1'b0;
    in_b_neg = 1'b0;
    case (func3)
      3'b001: begin in_a_neg = op_a[XLEN-1]; in_b_neg = op_b[XLEN-1]; end
      3'b010: begin in_a_neg = op_a[XLEN-1]; end
      3'b100,
      3'b110: begin in_a_neg = op_a[XLEN-1]; in_b_neg = op_b[XLEN-1]; end
      default: begin in_a_neg = 1'b0; in_b_neg = 1'b0; end
    endcase
    in_mag_a = in_a_neg ? (~op_a + 1'b1) : op_a;
    in_mag_b = in_b_neg ? (~op_b + 1'b1) : op_b;
    div_zero = func3[2] && (op_b == '0);
    div_ovf  = func3[2] && !func3[0] && (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);
    special_res = '0;
    if (div_zero)
      special_res = func3[1] ? op_a : '1;
    else if (div_ovf)
      special_res = func3[1] ? '0 : op_a;
  end

  // One shift-add or restoring-division step on the shared accumulator
  always_comb begin
    // Multiply: high half accumulates, multiplier bits shift out of the low half
    mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mag_a} : '0);
    mul_next = {mul_sum, acc[XLEN-1:1]};
    // Divide: high half is the partial remainder, low half shifts dividend out / quotient in
    div_shift = acc[2*XLEN-1:XLEN-1];
    div_diff  = div_shift - {1'b0, mag_b};
    if (div_diff[XLEN])
      div_next = {div_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0};
    else
      div_next = {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
  end

  // Sign correction and final result selection
  always_comb begin
    prod = (a_neg ^ b_neg) ? (~acc + 1'b1) : acc;
    quot = (a_neg ^ b_neg) ? (~acc[XLEN-1:0] + 1'b1) : acc[XLEN-1:0];
    remv = a_neg ? (~acc[2*XLEN-1:XLEN] + 1'b1) : acc[2*XLEN-1:XLEN];
    case (f3_q)
      3'b000:  fix_res = prod[XLEN-1:0];
      3'b001,
      3'b010,
      3'b011:  fix_res = prod[2*XLEN-1:XLEN];
      3'b100,
      3'b101:  fix_res = quot;
      default: fix_res = remv;
    endcase
  end

  // Control FSM with registered busy/done/result
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      cnt    <= '0;
      f3_q   <= '0;
      a_neg  <= 1'b0;
      b_neg  <= 1'b0;
      mag_a  <= '0;
      mag_b  <= '0;
      acc    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start && !flush) begin
            f3_q  <= func3;
            a_neg <= in_a_neg;
            b_neg <= in_b_neg;
            mag_a <= in_mag_a;
            mag_b <= in_mag_b;
            if (div_zero || div_ovf) begin
              result <= special_res;
              done   <= 1'b1;
              state  <= S_DONE;
            end else begin
              acc   <= func3[2] ? {{XLEN{1'b0}}, in_mag_a} : {{XLEN{1'b0}}, in_mag_b};
              cnt   <= CNT_W'(XLEN);
              busy  <= 1'b1;
              state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          if (flush) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            acc <= f3_q[2] ? div_next : mul_next;
            cnt <= cnt - 1'b1;
            if (cnt == CNT_W'(1))
              state <= S_FIX;
          end
        end
        S_FIX: begin
          busy <= 1'b0;
          if (flush) begin
            state <= S_IDLE;
          end else begin
            result <= fix_res;
            done   <= 1'b1;
            state  <= S_DONE;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - directed-vector self-checking bench for muldiv_unit
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  func3 = 3'b000;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int n_checks = 0;
  int n_fail   = 0;

  muldiv_unit #(.XLEN(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .flush  (flush),
    .func3  (func3),
    .op_a   (op_a),
    .op_b   (op_b),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // inj: 0 none, 1 extra start, 2 flush, 3 reset with start; applied during cycle inj_cyc
  // exp_lat = 0 means no done is expected
  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat,
                        input int inj, input int inj_cyc);
    int cyc;
    int dones;
    int done_cyc;
    int busy_n;
    int last;
    logic [31:0] res_at_done;
    logic [31:0] prev;
    prev = result;
    res_at_done = '0;
    func3 = f3;
    op_a = a;
    op_b = b;
    start = 1'b1;
    tick();
    start = 1'b0;
    op_a = 32'h5A5A_1234;
    op_b = 32'h0000_0003;
    func3 = ~f3;
    cyc = 1;
    dones = 0;
    done_cyc = -1;
    busy_n = 0;
    last = (inj >= 2) ? inj_cyc + 1 : 40;
    while (cyc <= last) begin
      if (done) begin
        dones++;
        if (done_cyc < 0) begin
          done_cyc = cyc;
          res_at_done = result;
        end
      end
      if (busy) busy_n++;
      if (inj >= 2 && cyc == inj_cyc + 1) begin
        check({tag, "_busy_after"}, {31'b0, busy}, 32'd0);
        check({tag, "_done_after"}, {31'b0, done}, 32'd0);
        check({tag, "_res_after"}, result, (inj == 3) ? 32'd0 : prev);
      end
      if (cyc == inj_cyc) begin
        case (inj)
          1: begin start = 1'b1; func3 = 3'b000; op_a = 32'd100; op_b = 32'd100; end
          2: flush = 1'b1;
          3: begin rst = 1'b1; start = 1'b1; end
          default: ;
        endcase
      end
      tick();
      start = 1'b0;
      flush = 1'b0;
      rst   = 1'b0;
      cyc++;
    end
    if (exp_lat > 0) begin
      check({tag, "_lat"}, done_cyc, exp_lat);
      check({tag, "_res"}, res_at_done, exp_res);
      check({tag, "_ndone"}, dones, 32'd1);
      check({tag, "_busy_cycles"}, busy_n, exp_lat - 1);
      check({tag, "_held"}, result, exp_res);
    end else begin
      check({tag, "_ndone"}, dones, 32'd0);
    end
  endtask

  initial begin
    rst = 1'b1;
    tick();
    tick();
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_result", result, 32'd0);
    rst = 1'b0;
    tick();

    run_op("mul_7_m3",   3'b000, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, 0, 0);
    run_op("mulh_min",   3'b001, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 34, 0, 0);
    run_op("mulhu_min",  3'b011, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 34, 0, 0);
    run_op("mulhsu_min", 3'b010, 32'h8000_0000,  32'h8000_0000, 32'hC000_0000, 34, 0, 0);
    run_op("mul_min",    3'b000, 32'h8000_0000,  32'h8000_0000, 32'h0000_0000, 34, 0, 0);
    run_op("mulhu_max",  3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 34, 0, 0);
    run_op("div_m7_2",   3'b100, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 34, 0, 0);
    run_op("rem_m7_2",   3'b110, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 34, 0, 0);
    run_op("divu_big",   3'b101, 32'hFFFF_FFF9,  32'd2,         32'h7FFF_FFFC, 34, 0, 0);
    run_op("remu_big",   3'b111, 32'hFFFF_FFF9,  32'd2,         32'h0000_0001, 34, 0, 0);
    run_op("div_7_m2",   3'b100, 32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 34, 0, 0);
    run_op("rem_7_m2",   3'b110, 32'd7,          32'hFFFF_FFFE, 32'h0000_0001, 34, 0, 0);
    run_op("div_by0",    3'b100, 32'd5,          32'd0,         32'hFFFF_FFFF, 1, 0, 0);
    run_op("remu_by0",   3'b111, 32'd5,          32'd0,         32'h0000_0005, 1, 0, 0);
    run_op("div_ovf",    3'b100, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1, 0, 0);
    run_op("rem_ovf",    3'b110, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000, 1, 0, 0);

    run_op("mul_restart", 3'b000, 32'd7,   32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, 1, 10);
    run_op("div_flush",   3'b100, 32'd100, 32'd7,         32'd0,         0,  2, 20);
    run_op("divu_after",  3'b101, 32'd100, 32'd7,         32'd14,        34, 0, 0);
    run_op("rem_rst",     3'b110, 32'd100, 32'd7,         32'd0,         0,  3, 15);
    run_op("rem_reissue", 3'b110, 32'd100, 32'd7,         32'd2,         34, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
